// File: rtl/wb_pkg.sv
// Shared definitions for the writeback merge unit.
//   - wb_size_e : load size encodings (byte/half/word/double)
//   - wb_entry_t: queued writeback entry {reg_idx, data}, sized for the
//                 widest legal configuration (REG_W <= 8, DATA_WIDTH <= 64)
//   - wb_log2   : ceiling log2 for deriving pointer/index widths
//   - PTR_W/CH_W: pointer and channel-index widths of the default build
//                 (FIFO_DEPTH=4, NUM_CH=2)
package wb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } wb_size_e;

  localparam int MAX_REG_W  = 8;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic [MAX_REG_W-1:0]  reg_idx;
    logic [MAX_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic int wb_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int PTR_W = wb_log2(4);
  localparam int CH_W  = wb_log2(2);

endpackage

// File: rtl/wb_chan_fifo.sv
// Single-clock per-channel writeback FIFO.
// Ports: clock, reset (synchronous, active-low), push/din (write side),
//        pop/head (read side, head is the current oldest entry),
//        full, empty, count (occupancy 0..DEPTH).
// Push while full and pop while empty are ignored.
module wb_chan_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  din,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [wb_log2(DEPTH):0]    count
);

  localparam int AW = wb_log2(DEPTH);

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/wb_merge_unit.sv
// Multi-channel writeback merge unit.
// Formats each channel's result at enqueue (ALU pass-through or load data
// lane-selected and zero/sign-extended), buffers it in a per-channel FIFO,
// and round-robin arbitrates FIFO heads onto one register-file write port.
// Ports: clock, reset (sync, active-low); per-channel ch_valid/ch_ready
//        handshake with ch_write, ch_sel, ch_reg, ch_alu, ch_mem, ch_size,
//        ch_unsigned, ch_addr_lo; registered write/write_reg/write_data;
//        busy (any FIFO non-empty); retire_count; report (trace enable).
// Build option: define WB_TRACE_EN to add a cycle counter and a per-cycle
// $display trace while report==1. Without it, report is ignored.
module wb_merge_unit
  import wb_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int REG_W      = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  input  logic [NUM_CH-1:0]            ch_write,
  input  logic [NUM_CH-1:0]            ch_sel,
  input  logic [NUM_CH*REG_W-1:0]      ch_reg,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_alu,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_mem,
  input  logic [NUM_CH*2-1:0]          ch_size,
  input  logic [NUM_CH-1:0]            ch_unsigned,
  input  logic [NUM_CH*3-1:0]          ch_addr_lo,
  output logic                         write,
  output logic [REG_W-1:0]             write_reg,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic                         busy,
  output logic [31:0]                  retire_count,
  input  logic                         report
);

  localparam int AW = wb_log2(FIFO_DEPTH);
  localparam int GW = (NUM_CH > 1) ? wb_log2(NUM_CH) : 1;

  // Byte-offset masks: a half aligns to an even byte, a word on a 64-bit
  // bus is picked by addr[2] only, and a 32-bit word is always the low word.
  localparam logic [2:0] BYTE_MASK = 3'(DATA_WIDTH/8 - 1);
  localparam logic [2:0] HALF_MASK = 3'(DATA_WIDTH/8 - 2);
  localparam logic [2:0] WORD_MASK = (DATA_WIDTH == 64) ? 3'b100 : 3'b000;

  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [DATA_WIDTH-1:0] raw,
    input wb_size_e              size,
    input logic                  uns,
    input logic [2:0]            addr
  );
    logic [2:0]  lane;
    logic [63:0] wide;
    logic [63:0] ext;
    case (size)
      SZ_BYTE: lane = addr & BYTE_MASK;
      SZ_HALF: lane = addr & HALF_MASK;
      SZ_WORD: lane = addr & WORD_MASK;
      default: lane = 3'b000;
    endcase
    wide = 64'(raw) >> {lane, 3'b000};
    case (size)
      SZ_BYTE: ext = {{56{~uns & wide[7]}},  wide[7:0]};
      SZ_HALF: ext = {{48{~uns & wide[15]}}, wide[15:0]};
      SZ_WORD: ext = {{32{~uns & wide[31]}}, wide[31:0]};
      default: ext = (DATA_WIDTH == 64) ? wide : {{32{~uns & wide[31]}}, wide[31:0]};
    endcase
    return DATA_WIDTH'(ext);
  endfunction

  wb_entry_t         head [NUM_CH];
  logic [AW:0]       occ  [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     rr_next;
  logic              any;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wb_entry_t ent;

    always_comb begin
      ent         = '0;
      ent.reg_idx = MAX_REG_W'(ch_reg[c*REG_W +: REG_W]);
      ent.data    = MAX_DATA_W'(ch_sel[c] ?
                      fmt_load(ch_mem[c*DATA_WIDTH +: DATA_WIDTH],
                               wb_size_e'(ch_size[c*2 +: 2]),
                               ch_unsigned[c],
                               ch_addr_lo[c*3 +: 3]) :
                      ch_alu[c*DATA_WIDTH +: DATA_WIDTH]);
    end

    assign ch_ready[c] = reset & ~full[c];
    // Entries that would not write the register file are accepted but dropped.
    assign push[c] = ch_valid[c] & ch_ready[c] & ch_write[c] &
                     (ch_reg[c*REG_W +: REG_W] != '0);

    wb_chan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[c]),
      .din   (ent),
      .pop   (pop[c]),
      .head  (head[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .count (occ[c])
    );
  end

  // First non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    any   = 1'b0;
    grant = '0;
    pop   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any && !empty[idx]) begin
        any   = 1'b1;
        grant = GW'(idx);
      end
    end
    if (any) pop[grant] = 1'b1;
    rr_next = (grant == GW'(NUM_CH-1)) ? '0 : grant + 1'b1;
  end

  assign busy = |(~empty);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr       <= '0;
      write        <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
      retire_count <= '0;
    end else if (any) begin
      rr_ptr       <= rr_next;
      write        <= 1'b1;
      write_reg    <= REG_W'(head[grant].reg_idx);
      write_data   <= DATA_WIDTH'(head[grant].data);
      retire_count <= retire_count + 32'd1;
    end else begin
      write        <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end
  end

`ifdef WB_TRACE_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (report) begin
        $display("[WB%0d] cyc=%0d grant=%0d valid_grant=%0b write=%0b reg=%0d data=%h",
                 CORE, cycle_cnt, grant, any, write, write_reg, write_data);
        for (int c = 0; c < NUM_CH; c++) begin
          $display("[WB%0d]   ch%0d occ=%0d", CORE, c, occ[c]);
        end
      end
    end
  end
`else
  // Trace-only signals are tied off here so the default build stays quiet.
  logic unused_trace;
  always_comb begin
    unused_trace = report | (CORE < 0);
    for (int c = 0; c < NUM_CH; c++) begin
      unused_trace = unused_trace | (|occ[c]);
    end
  end
`endif

endmodule

// File: tb/tb_wb_merge_unit.sv
module tb_wb_merge_unit;
  localparam int DW  = 32;
  localparam int NCH = 2;
  localparam int RW  = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_valid, ch_ready, ch_write, ch_sel, ch_unsigned;
  logic [NCH*RW-1:0] ch_reg;
  logic [NCH*DW-1:0] ch_alu, ch_mem;
  logic [NCH*2-1:0]  ch_size;
  logic [NCH*3-1:0]  ch_addr_lo;
  logic              write, busy, report;
  logic [RW-1:0]     write_reg;
  logic [DW-1:0]     write_data;
  logic [31:0]       retire_count;

  always #5 clock = ~clock;

  wb_merge_unit #(.CORE(0), .DATA_WIDTH(DW), .NUM_CH(NCH), .FIFO_DEPTH(4), .REG_W(RW)) dut (
    .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_write(ch_write), .ch_sel(ch_sel), .ch_reg(ch_reg), .ch_alu(ch_alu),
    .ch_mem(ch_mem), .ch_size(ch_size), .ch_unsigned(ch_unsigned),
    .ch_addr_lo(ch_addr_lo), .write(write), .write_reg(write_reg),
    .write_data(write_data), .busy(busy), .retire_count(retire_count),
    .report(report)
  );

  int tests = 0;
  int fails = 0;
  int exp_retire = 0;

  typedef struct packed { logic [RW-1:0] r; logic [DW-1:0] d; } wr_t;
  wr_t obs[$];

  always @(negedge clock) if (write === 1'b1) obs.push_back({write_reg, write_data});

  typedef struct {
    int         ch;
    logic       sel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [1:0] sz;
    logic       uns;
    logic [2:0] addr;
    logic [31:0] exp;
  } fvec_t;
  fvec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ch_valid = '0; ch_write = '1; ch_sel = '0; ch_reg = '0; ch_alu = '0;
    ch_mem = '0; ch_size = '0; ch_unsigned = '0; ch_addr_lo = '0;
  endtask

  task automatic drive(input int c, input logic [RW-1:0] r, input logic sel,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [1:0] sz, input logic uns, input logic [2:0] addr);
    ch_valid[c] = 1'b1;
    ch_write[c] = 1'b1;
    ch_sel[c] = sel;
    ch_reg[c*RW +: RW] = r;
    ch_alu[c*DW +: DW] = alu;
    ch_mem[c*DW +: DW] = mem;
    ch_size[c*2 +: 2] = sz;
    ch_unsigned[c] = uns;
    ch_addr_lo[c*3 +: 3] = addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ[2];
    int mrr;
    int notready_seen;
    int n;
    wr_t exp0[$], exp1[$], got0[$], got1[$];

    vecs[0]  = '{0, 1'b1, 32'h0, 32'h80FF7F01, 2'b00, 1'b0, 3'd3, 32'hFFFFFF80};
    vecs[1]  = '{0, 1'b1, 32'h0, 32'h80FF7F01, 2'b00, 1'b1, 3'd3, 32'h00000080};
    vecs[2]  = '{0, 1'b1, 32'h0, 32'h80FF7F01, 2'b01, 1'b0, 3'd2, 32'hFFFF80FF};
    vecs[3]  = '{0, 1'b1, 32'h0, 32'h80FF7F01, 2'b00, 1'b0, 3'd1, 32'h0000007F};
    vecs[4]  = '{0, 1'b1, 32'h0, 32'h80FF7F01, 2'b01, 1'b1, 3'd0, 32'h00007F01};
    vecs[5]  = '{0, 1'b1, 32'h0, 32'h80FF7F01, 2'b01, 1'b1, 3'd2, 32'h000080FF};
    vecs[6]  = '{0, 1'b1, 32'h0, 32'h80FF7F01, 2'b10, 1'b0, 3'd0, 32'h80FF7F01};
    vecs[7]  = '{0, 1'b1, 32'h0, 32'h80FF7F01, 2'b11, 1'b0, 3'd0, 32'h80FF7F01};
    vecs[8]  = '{0, 1'b0, 32'hDEADBEEF, 32'h80FF7F01, 2'b00, 1'b0, 3'd3, 32'hDEADBEEF};
    vecs[9]  = '{0, 1'b1, 32'h0, 32'h80FF7F01, 2'b00, 1'b0, 3'd2, 32'hFFFFFFFF};
    vecs[10] = '{1, 1'b1, 32'h0, 32'h80FF7F01, 2'b00, 1'b1, 3'd0, 32'h00000001};

    report = 1'b0;
    idle_inputs();

    // Reset held 3 cycles with both channels requesting.
    reset = 1'b0;
    ch_valid = 2'b11;
    ch_reg = {5'd2, 5'd1};
    repeat (3) step();
    check("rst_ready", ch_ready, 2'b00);
    check("rst_write", write, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_retire", retire_count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    idle_inputs();
    step();

    // Single ALU write: accepted at edge N, visible after edge N+1 for one cycle.
    drive(0, 5'd5, 1'b0, 32'h1234, 32'h0, 2'b00, 1'b0, 3'd0);
    step();
    idle_inputs();
    check("alu_early_write", write, 0);
    step();
    check("alu_write", write, 1);
    check("alu_write_reg", write_reg, 5);
    check("alu_write_data", write_data, 32'h1234);
    step();
    check("alu_write_drop", write, 0);
    exp_retire = 1;
    check("alu_retire", retire_count, exp_retire);

    // Formatting table.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ch, 5'd9, vecs[i].sel, vecs[i].alu, vecs[i].mem,
            vecs[i].sz, vecs[i].uns, vecs[i].addr);
      step();
      idle_inputs();
      step();
      check($sformatf("fmt%0d_write", i), write, 1);
      check($sformatf("fmt%0d_reg", i), write_reg, 9);
      check($sformatf("fmt%0d_data", i), write_data, vecs[i].exp);
      exp_retire++;
      step();
    end

    // Arbitration: two simultaneous pairs, rr_ptr back at 0 each time.
    for (int p = 0; p < 2; p++) begin
      drive(0, 5'(1 + 2*p), 1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 3'd0);
      drive(1, 5'(2 + 2*p), 1'b0, 32'h22, 32'h0, 2'b00, 1'b0, 3'd0);
      step();
      idle_inputs();
      step();
      check($sformatf("arb_pair%0d_first", p), write_reg, 1 + 2*p);
      step();
      check($sformatf("arb_pair%0d_second", p), write_reg, 2 + 2*p);
      step();
      exp_retire += 2;
    end
    // ch0 entry pops while a new pair lands; rr_ptr then favours ch1.
    drive(0, 5'd5, 1'b0, 32'h55, 32'h0, 2'b00, 1'b0, 3'd0);
    step();
    idle_inputs();
    drive(0, 5'd6, 1'b0, 32'h66, 32'h0, 2'b00, 1'b0, 3'd0);
    drive(1, 5'd7, 1'b0, 32'h77, 32'h0, 2'b00, 1'b0, 3'd0);
    step();
    idle_inputs();
    check("arb_pend_first", write_reg, 5);
    step();
    check("arb_pend_second", write_reg, 7);
    step();
    check("arb_pend_third", write_reg, 6);
    step();
    exp_retire += 3;
    check("arb_retire", retire_count, exp_retire);
    step();

    // Backpressure: occupancy model, rr_ptr=1 after last grant to ch0.
    obs.delete();
    occ[0] = 0; occ[1] = 0; mrr = 1; notready_seen = 0;
    for (int i = 0; i < 12; i++) begin
      int g;
      logic [1:0] acc;
      drive(0, 5'(1 + i),  1'b0, 32'hA000_0000 + i, 32'h0, 2'b00, 1'b0, 3'd0);
      drive(1, 5'(17 + i), 1'b0, 32'hB000_0000 + i, 32'h0, 2'b00, 1'b0, 3'd0);
      #2;
      if (ch_ready != 2'b11) notready_seen++;
      g = -1;
      for (int k = 0; k < 2; k++) begin
        int idx;
        idx = (mrr + k) % 2;
        if (g < 0 && occ[idx] > 0) g = idx;
      end
      acc[0] = (occ[0] < 4);
      acc[1] = (occ[1] < 4);
      check($sformatf("bp_ready_c%0d", i), ch_ready, acc);
      if (acc[0]) exp0.push_back({5'(1 + i), 32'hA000_0000 + i});
      if (acc[1]) exp1.push_back({5'(17 + i), 32'hB000_0000 + i});
      if (g >= 0) begin
        occ[g]--;
        mrr = (g + 1) % 2;
      end
      occ[0] += int'(acc[0]);
      occ[1] += int'(acc[1]);
      step();
    end
    idle_inputs();
    n = 0;
    while ((busy || write) && n < 40) begin
      step();
      n++;
    end
    check("bp_drain_in_time", n < 40, 1);
    check("bp_notready_seen", notready_seen > 0, 1);
    check("bp_total_writes", obs.size(), exp0.size() + exp1.size());
    foreach (obs[i]) begin
      if (obs[i].r < 17) got0.push_back(obs[i]);
      else got1.push_back(obs[i]);
    end
    check("bp_ch0_count", got0.size(), exp0.size());
    check("bp_ch1_count", got1.size(), exp1.size());
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      check($sformatf("bp_ch0_entry%0d", i), got0[i], exp0[i]);
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      check($sformatf("bp_ch1_entry%0d", i), got1[i], exp1[i]);
    exp_retire += exp0.size() + exp1.size();
    check("bp_retire", retire_count, exp_retire);

    // Drop rule: reg 0 on ch0, write=0 on ch1.
    obs.delete();
    drive(0, 5'd0, 1'b0, 32'hAAAA, 32'h0, 2'b00, 1'b0, 3'd0);
    drive(1, 5'd7, 1'b0, 32'hBBBB, 32'h0, 2'b00, 1'b0, 3'd0);
    ch_write[1] = 1'b0;
    #2;
    check("drop_accepted", ch_ready, 2'b11);
    step();
    idle_inputs();
    repeat (3) step();
    check("drop_no_write", obs.size(), 0);
    check("drop_retire", retire_count, exp_retire);
    check("drop_busy", busy, 0);

    // Reset mid-operation discards queued entries.
    for (int k = 0; k < 3; k++) begin
      drive(0, 5'(10 + k), 1'b0, 32'h100 + k, 32'h0, 2'b00, 1'b0, 3'd0);
      drive(1, 5'(20 + k), 1'b0, 32'h200 + k, 32'h0, 2'b00, 1'b0, 3'd0);
      step();
    end
    idle_inputs();
    check("mid_busy_before_rst", busy, 1);
    reset = 1'b0;
    #2;
    check("mid_ready_in_rst", ch_ready, 2'b00);
    step();
    reset = 1'b1;
    check("mid_write_after_rst", write, 0);
    obs.delete();
    repeat (6) step();
    check("mid_no_writes", obs.size(), 0);
    check("mid_busy", busy, 0);
    check("mid_retire", retire_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_merge_unit.md
Name: wb_merge_unit

Overview:
Parameterised successor to the single-lane writeback stage. Accepts NUM_CH independent writeback channels, such as the ALU pipe and the load pipe, each with a valid/ready handshake. Formats load data by size, sign and byte offset, buffers each channel in its own FIFO, and round-robin arbitrates the buffered entries onto the single register-file write port. Sits between the memory-stage outputs and the register file.

Parameters:
CORE, 0, core index used in trace output
DATA_WIDTH, 32, datapath width; only 32 and 64 are legal
NUM_CH, 2, number of writeback channels (1..8)
FIFO_DEPTH, 4, entries per channel FIFO; power of two, at least 2
REG_W, 5, register index width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
ch_valid  in  NUM_CH  per-channel request valid
ch_ready  out  NUM_CH  per-channel FIFO can accept
ch_write  in  NUM_CH  per-channel opWrite
ch_sel  in  NUM_CH  per-channel select: 1 = memory data, 0 = ALU result
ch_reg  in  NUM_CH*REG_W  per-channel destination register
ch_alu  in  NUM_CH*DATA_WIDTH  per-channel ALU result
ch_mem  in  NUM_CH*DATA_WIDTH  per-channel raw memory data
ch_size  in  NUM_CH*2  load size: 00 byte, 01 half, 10 word, 11 double (word when DATA_WIDTH=32)
ch_unsigned  in  NUM_CH  1 = zero-extend the load, 0 = sign-extend
ch_addr_lo  in  NUM_CH*3  low address bits used for lane select
write  out  1  register-file write enable
write_reg  out  REG_W  register-file write index
write_data  out  DATA_WIDTH  register-file write data
busy  out  1  at least one FIFO is non-empty
retire_count  out  32  count of issued writes
report  in  1  trace enable

Behaviour:
- Reset: reset==0 sampled at a clock edge clears the following: all FIFO pointers and counts; the round-robin pointer (to 0); write, write_reg and write_data (to 0); retire_count (to 0). ch_ready is forced to 0 while reset==0, and busy is 0 after reset. Reset mid-operation discards all queued entries; none are ever emitted.
- Handshake: a channel is accepted on a cycle where ch_valid & ch_ready are both high. ch_ready = FIFO not full, with no pass-through. A full FIFO stays not-ready even in a cycle where it is being popped.
- Formatting happens at enqueue:
  - ch_sel==0: data is ch_alu.
  - ch_sel==1, byte: select byte lane ch_addr_lo[log2(DATA_WIDTH/8)-1:0].
  - Half: select the lane addressed by the upper address bits.
  - Word: low word when DATA_WIDTH=32; selected by ch_addr_lo[2] when DATA_WIDTH=64.
  - Double: full width.
  - Extension is zero or sign according to ch_unsigned.
- Drop rule: an accepted entry with ch_write==0 or ch_reg==0 is consumed and not stored.
- Arbitration:
  - One pop per cycle.
  - The grant goes to the first non-empty FIFO starting at rr_ptr, searching ascending with wrap.
  - After a grant, rr_ptr = (grant+1) mod NUM_CH.
  - rr_ptr is unchanged when nothing is granted.
- Output registers:
  - On a pop: write=1, write_reg and write_data come from the FIFO head.
  - Otherwise write=0, with write_reg and write_data forced to 0.
  - Latency: acceptance at edge N gives the earliest write=1 in the cycle after edge N+1 (output registered).
  - Each entry is written exactly once.
  - Per-channel order is preserved; there is no ordering between channels.
- retire_count increments by 1 on each pop and wraps at 2^32.
- busy is combinational: OR of all FIFO non-empty flags.

Optional Feature:
WB_TRACE_EN.
- Defined: the block includes a 32-bit cycle counter, cleared by reset. When report==1 on a clock edge, it prints via $display:
  - the cycle, CORE and grant index;
  - write, write_reg and write_data;
  - per-channel FIFO occupancy.
- Undefined: no counter, no $display, and the report input is ignored. Functional behaviour is identical in both builds.

Decomposition:
- Shared package wb_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE;
  - the entry struct {reg, data};
  - the localparams PTR_W = log2(FIFO_DEPTH) and CH_W = log2(NUM_CH).
- One sub-module, wb_chan_fifo: single-clock FIFO with synchronous active-low reset, push/pop/full/empty/count. It is instantiated NUM_CH times via generate.
- Formatting and arbitration stay in the top module.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with ch_valid=2'b11 -> ch_ready=0, write=0, write_reg=0, write_data=0, retire_count=0, busy=0.
2. Single ALU write: ch0 valid, reg=5, alu=0x1234, sel=0, accepted at edge N -> write=1, write_reg=5, write_data=0x1234 for exactly one cycle after edge N+1; retire_count=1.
3. Load formatting, DATA_WIDTH=32, mem=0x80FF7F01:
   - byte, addr_lo=3, signed -> 0xFFFFFF80
   - byte, addr_lo=3, unsigned -> 0x00000080
   - half, addr_lo=2, signed -> 0xFFFF80FF
   - byte, addr_lo=1, signed -> 0x0000007F
4. Arbitration: ch0 reg=1 and ch1 reg=2 accepted together -> reg 1 then reg 2 on consecutive cycles. A second simultaneous pair (reg 3, reg 4) -> reg 3 then reg 4, since rr_ptr has returned to 0. With a third pair arriving while one entry is pending, the grant order follows rr_ptr.
5. Backpressure: FIFO_DEPTH=4, both channels valid every cycle for 12 cycles with incrementing regs -> ch_ready drops when a FIFO is full. Every accepted entry is emitted exactly once, in per-channel order, and retire_count equals the number of accepted entries with write=1 and reg≠0.
6. Drop and reset: ch0 reg=0 write=1 and ch1 write=0 reg=7 -> both accepted, no write, retire_count unchanged. Then queue 3 entries and pulse reset=0 for 1 cycle -> no writes afterwards, busy=0.
